// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage ahead of the main control decoder. Owns the
//                program counter, issues one word fetch at a time over a
//                req/ack handshake, holds the fetched instruction under a
//                valid/ready handshake and selects the next PC (sequential,
//                branch or jump).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // instruction memory request side
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o32,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i32,
  // held-instruction side towards the decoder / datapath
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o32,
  output logic [5:0]  op_o6,
  output logic [5:0]  funct_o6,
  output logic [31:0] pc_o32,
  output logic [31:0] pc_plus4_o32,
  // next-PC steering from the decoder for the held instruction
  input  logic        pc_j_i,
  input  logic        branch_taken_i
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // The two low address bits are forced to zero so every fetch address is
  // word aligned even if the parameter is mis-set; all later targets derive
  // from aligned values and stay aligned by construction.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;   // address of the next/current fetch
  logic [31:0] instr_q, instr_d;         // held instruction word
  logic [31:0] pc_q, pc_d;               // address of the held instruction

  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  // --------------------------------------------------------------------------
  // Next-PC arithmetic, all modulo 2^32 (carry out of the adders is dropped)
  // --------------------------------------------------------------------------

  // Candidate targets derived from the held instruction and its address
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    branch_target = pc_plus4 + branch_offset;
    jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  end

  // Target select: jump outranks a taken branch, otherwise fall through
  always_comb begin
    next_pc = pc_plus4;
    if (pc_j_i) begin
      next_pc = jump_target;
    end else if (branch_taken_i) begin
      next_pc = branch_target;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  // State register; reset abandons any outstanding fetch immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: fetch address, held instruction and its PC
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC_ALIGNED;
      instr_q    <= 32'd0;
      pc_q       <= 32'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // Next-state and handshake outputs. The memory ack is looked at only in
  // FETCH, which is what makes a late ack from an abandoned request harmless.
  // The steering inputs only matter in HOLD when the consumer takes the word.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        // single settling cycle after reset release
        state_d = FETCH;
      end

      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          instr_d = imem_rdata_i32;
          pc_d    = fetch_pc_q;
          state_d = HOLD;
        end
      end

      HOLD: begin
        instr_valid_o = 1'b1;
        if (instr_ready_i) begin
          fetch_pc_d = next_pc;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output wiring
  // --------------------------------------------------------------------------

  // Address is registered, so it cannot move while a request is pending
  assign imem_addr_o32 = fetch_pc_q;
  assign instr_o32     = instr_q;
  assign op_o6         = instr_q[31:26];
  assign funct_o6      = instr_q[5:0];
  assign pc_o32        = pc_q;
  assign pc_plus4_o32  = pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. The bench plays the
//                instruction memory and the downstream consumer, and predicts
//                every fetch address from the next-PC rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o32;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i32 = 32'd0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o32;
  logic [5:0]  op_o6;
  logic [5:0]  funct_o6;
  logic [31:0] pc_o32;
  logic [31:0] pc_plus4_o32;
  logic        pc_j_i = 1'b0;
  logic        branch_taken_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .imem_req_o     (imem_req_o),
    .imem_addr_o32  (imem_addr_o32),
    .imem_ack_i     (imem_ack_i),
    .imem_rdata_i32 (imem_rdata_i32),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o32      (instr_o32),
    .op_o6          (op_o6),
    .funct_o6       (funct_o6),
    .pc_o32         (pc_o32),
    .pc_plus4_o32   (pc_plus4_o32),
    .pc_j_i         (pc_j_i),
    .branch_taken_i (branch_taken_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Reference model: next fetch address from the architectural rules,
  // computed with wide integer arithmetic and reduced modulo 2^32.
  // --------------------------------------------------------------------------
  function automatic logic [31:0] model_seq(input logic [31:0] pc);
    longint m, s;
    m = 64'h1_0000_0000;
    s = (longint'({32'd0, pc}) + 4) % m;
    return s[31:0];
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input bit j, input bit bt);
    longint m, seq, tgt, imm, idx;
    m   = 64'h1_0000_0000;
    seq = longint'({32'd0, model_seq(pc)});
    imm = longint'($signed(ins[15:0]));
    idx = longint'({38'd0, ins[25:0]});
    if (j)       tgt = (seq / 268435456) * 268435456 + idx * 4;
    else if (bt) tgt = seq + imm * 4;
    else         tgt = seq;
    tgt = ((tgt % m) + m) % m;
    return tgt[31:0];
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus drivers (they report observations; the tests judge them)
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni         = 1'b0;
    imem_ack_i     = 1'b0;
    instr_ready_i  = 1'b0;
    pc_j_i         = 1'b0;
    branch_taken_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  // Act as memory: wait for a request, hold it 'delay' cycles, then ack.
  // 'stable' drops if req/addr move or valid rises before the ack.
  task automatic mem_serve(input logic [31:0] rdata, input int delay,
                           output logic [31:0] addr, output bit ok, output bit stable);
    int waited;
    waited = 0;
    ok     = 1'b1;
    stable = 1'b1;
    addr   = 32'd0;
    while (imem_req_o !== 1'b1) begin
      step();
      waited++;
      if (waited > 20) begin
        ok = 1'b0;
        return;
      end
    end
    addr = imem_addr_o32;
    if (instr_valid_o !== 1'b0) stable = 1'b0;
    for (int i = 0; i < delay; i++) begin
      step();
      if (imem_req_o !== 1'b1 || imem_addr_o32 !== addr || instr_valid_o !== 1'b0) stable = 1'b0;
    end
    imem_ack_i     = 1'b1;
    imem_rdata_i32 = rdata;
    step();
    imem_ack_i     = 1'b0;
    imem_rdata_i32 = $urandom;
  endtask

  // Act as consumer: stall 'delay' cycles, then take the word with the given
  // steering. Steering inputs are scrambled outside the accept cycle.
  task automatic consume(input int delay, input bit j, input bit bt, output bit stable);
    logic [31:0] w, p;
    stable = 1'b1;
    w = instr_o32;
    p = pc_o32;
    for (int i = 0; i < delay; i++) begin
      pc_j_i         = ($urandom_range(0, 1) != 0);
      branch_taken_i = ($urandom_range(0, 1) != 0);
      step();
      if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || instr_o32 !== w || pc_o32 !== p)
        stable = 1'b0;
    end
    instr_ready_i  = 1'b1;
    pc_j_i         = j;
    branch_taken_i = bt;
    step();
    instr_ready_i  = 1'b0;
    pc_j_i         = ($urandom_range(0, 1) != 0);
    branch_taken_i = ($urandom_range(0, 1) != 0);
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    step();
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    n_checks++; if (instr_o32 !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr_o32); end
    n_checks++; if (pc_o32 !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_o32); end
    rst_ni = 1'b1;
    #1;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", imem_req_o); end
    step();
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req_o); end
    n_checks++; if (imem_addr_o32 !== RESET_PC) begin n_fail++; $display("FAIL first_addr: got %h want %h", imem_addr_o32, RESET_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] w, a;
    bit ok, st;
    int unsigned vc[3];
    apply_reset();
    instr_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      mem_serve(w, 0, a, ok, st);
      vc[k] = cyc;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_req_timeout: got none want req (fetch %0d)", k); end
      n_checks++; if (a !== 32'(k * 4)) begin n_fail++; $display("FAIL seq_addr: got %h want %h", a, 32'(k * 4)); end
      n_checks++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_valid: got %b want 1", instr_valid_o); end
      n_checks++; if (pc_o32 !== 32'(k * 4)) begin n_fail++; $display("FAIL seq_pc: got %h want %h", pc_o32, 32'(k * 4)); end
      n_checks++; if (instr_o32 !== w) begin n_fail++; $display("FAIL seq_instr: got %h want %h", instr_o32, w); end
      step();
    end
    instr_ready_i = 1'b0;
    n_checks++; if (vc[1] - vc[0] != 2) begin n_fail++; $display("FAIL seq_spacing01: got %0d want 2", vc[1] - vc[0]); end
    n_checks++; if (vc[2] - vc[1] != 2) begin n_fail++; $display("FAIL seq_spacing12: got %0d want 2", vc[2] - vc[1]); end
  endtask

  task automatic test_ack_delay();
    logic [31:0] w, a;
    bit ok, st;
    apply_reset();
    mem_serve($urandom, 0, a, ok, st);
    consume(0, 1'b0, 1'b0, st);
    w = $urandom;
    mem_serve(w, 3, a, ok, st);
    n_checks++; if (a !== 32'h4) begin n_fail++; $display("FAIL dly_addr: got %h want 4", a); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL dly_stable: got %b want 1 (req/addr held, valid low)", st); end
    n_checks++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL dly_valid: got %b want 1", instr_valid_o); end
    n_checks++; if (instr_o32 !== w) begin n_fail++; $display("FAIL dly_instr: got %h want %h", instr_o32, w); end
    n_checks++; if (pc_o32 !== 32'h4) begin n_fail++; $display("FAIL dly_pc: got %h want 4", pc_o32); end
    consume(0, 1'b0, 1'b0, st);
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    bit ok, st;
    mem_serve(32'h8C41_0004, 0, a, ok, st);
    n_checks++; if (a !== 32'h8) begin n_fail++; $display("FAIL bp_addr: got %h want 8", a); end
    for (int i = 0; i < 5; i++) begin
      // a stray ack while holding must not disturb anything
      imem_ack_i     = 1'b1;
      imem_rdata_i32 = $urandom;
      pc_j_i         = 1'b1;
      step();
      n_checks++; if (instr_o32 !== 32'h8C41_0004) begin n_fail++; $display("FAIL bp_instr: got %h want 8c410004", instr_o32); end
      n_checks++; if (op_o6 !== 6'h23) begin n_fail++; $display("FAIL bp_op: got %h want 23", op_o6); end
      n_checks++; if (funct_o6 !== 6'h04) begin n_fail++; $display("FAIL bp_funct: got %h want 04", funct_o6); end
      n_checks++; if (pc_o32 !== 32'h8) begin n_fail++; $display("FAIL bp_pc: got %h want 8", pc_o32); end
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b want 0", imem_req_o); end
      n_checks++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", instr_valid_o); end
    end
    imem_ack_i = 1'b0;
    consume(0, 1'b0, 1'b0, st);
    n_checks++; if (imem_addr_o32 !== 32'hC) begin n_fail++; $display("FAIL bp_next: got %h want c", imem_addr_o32); end
  endtask

  task automatic test_branch();
    logic [31:0] a;
    bit ok, st;
    mem_serve(32'h0800_0040, 0, a, ok, st);      // jump to 0x100
    consume(0, 1'b1, 1'b0, st);
    mem_serve(32'h1000_FFFE, 0, a, ok, st);
    n_checks++; if (a !== 32'h100) begin n_fail++; $display("FAIL br_at100: got %h want 100", a); end
    n_checks++; if (pc_plus4_o32 !== 32'h104) begin n_fail++; $display("FAIL br_plus4: got %h want 104", pc_plus4_o32); end
    consume(0, 1'b0, 1'b1, st);
    mem_serve(32'h0800_0040, 0, a, ok, st);      // back to 0x100
    n_checks++; if (a !== 32'hFC) begin n_fail++; $display("FAIL br_taken: got %h want fc", a); end
    consume(0, 1'b1, 1'b0, st);
    mem_serve(32'h1000_FFFE, 0, a, ok, st);
    n_checks++; if (a !== 32'h100) begin n_fail++; $display("FAIL br_back: got %h want 100", a); end
    consume(0, 1'b0, 1'b0, st);
    mem_serve($urandom, 0, a, ok, st);
    n_checks++; if (a !== 32'h104) begin n_fail++; $display("FAIL br_not_taken: got %h want 104", a); end
    consume(0, 1'b0, 1'b0, st);
  endtask

  task automatic test_jump_priority();
    logic [31:0] a;
    bit ok, st;
    apply_reset();
    mem_serve(32'h1000_FFFD, 0, a, ok, st);      // branch -3 words from 0
    consume(0, 1'b0, 1'b1, st);
    mem_serve(32'h0800_0004, 0, a, ok, st);
    n_checks++; if (a !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL jp_neg_branch: got %h want fffffff8", a); end
    consume(0, 1'b1, 1'b0, st);
    mem_serve(32'h0800_0040, 0, a, ok, st);
    n_checks++; if (a !== 32'hF000_0010) begin n_fail++; $display("FAIL jp_region: got %h want f0000010", a); end
    n_checks++; if (pc_plus4_o32 !== 32'hF000_0014) begin n_fail++; $display("FAIL jp_plus4: got %h want f0000014", pc_plus4_o32); end
    consume(0, 1'b1, 1'b1, st);
    mem_serve($urandom, 0, a, ok, st);
    n_checks++; if (a !== 32'hF000_0100) begin n_fail++; $display("FAIL jp_priority: got %h want f0000100", a); end
    consume(0, 1'b0, 1'b0, st);
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] w, a;
    bit ok, st;
    apply_reset();
    mem_serve(32'h1000_FFFE, 0, a, ok, st);      // branch -2 words from 0
    consume(0, 1'b0, 1'b1, st);
    mem_serve($urandom, 0, a, ok, st);
    n_checks++; if (a !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_top: got %h want fffffffc", a); end
    n_checks++; if (pc_plus4_o32 !== 32'h0) begin n_fail++; $display("FAIL wr_plus4: got %h want 0", pc_plus4_o32); end
    consume(0, 1'b0, 1'b0, st);
    n_checks++; if (imem_addr_o32 !== 32'h0) begin n_fail++; $display("FAIL wr_next: got %h want 0", imem_addr_o32); end
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_req: got %b want 1", imem_req_o); end
    // drop reset mid-FETCH, between clock edges
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %b want 0", imem_req_o); end
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", instr_valid_o); end
    n_checks++; if (pc_o32 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc: got %h want 0", pc_o32); end
    n_checks++; if (instr_o32 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_instr: got %h want 0", instr_o32); end
    step();
    // release with a stale ack from the abandoned request
    rst_ni         = 1'b1;
    imem_ack_i     = 1'b1;
    imem_rdata_i32 = 32'hDEAD_BEEF;
    step();
    imem_ack_i = 1'b0;
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL stale_valid: got %b want 0", instr_valid_o); end
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL stale_req: got %b want 1", imem_req_o); end
    n_checks++; if (imem_addr_o32 !== RESET_PC) begin n_fail++; $display("FAIL stale_addr: got %h want %h", imem_addr_o32, RESET_PC); end
    step();
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL stale_valid2: got %b want 0", instr_valid_o); end
    w = $urandom;
    mem_serve(w, 1, a, ok, st);
    n_checks++; if (a !== RESET_PC) begin n_fail++; $display("FAIL restart_addr: got %h want %h", a, RESET_PC); end
    n_checks++; if (instr_o32 !== w) begin n_fail++; $display("FAIL restart_instr: got %h want %h", instr_o32, w); end
    consume(0, 1'b0, 1'b0, st);
  endtask

  task automatic test_random();
    logic [31:0] w, a, exp_pc;
    bit ok, st, st2, j, bt;
    int d, rd;
    apply_reset();
    exp_pc = RESET_PC;
    for (int k = 0; k < 40; k++) begin
      w  = $urandom;
      d  = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      j  = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 2) == 0);
      mem_serve(w, d, a, ok, st);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_timeout: got no req want req (txn %0d)", k); end
      n_checks++; if (a !== exp_pc) begin n_fail++; $display("FAIL rnd_addr: got %h want %h (txn %0d)", a, exp_pc, k); end
      n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL rnd_req_stable: got %b want 1 (txn %0d)", st, k); end
      n_checks++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL rnd_valid: got %b want 1", instr_valid_o); end
      n_checks++; if (instr_o32 !== w) begin n_fail++; $display("FAIL rnd_instr: got %h want %h", instr_o32, w); end
      n_checks++; if (pc_o32 !== exp_pc) begin n_fail++; $display("FAIL rnd_pc: got %h want %h", pc_o32, exp_pc); end
      n_checks++; if (op_o6 !== w[31:26]) begin n_fail++; $display("FAIL rnd_op: got %h want %h", op_o6, w[31:26]); end
      n_checks++; if (funct_o6 !== w[5:0]) begin n_fail++; $display("FAIL rnd_funct: got %h want %h", funct_o6, w[5:0]); end
      n_checks++; if (pc_plus4_o32 !== model_seq(exp_pc)) begin n_fail++; $display("FAIL rnd_plus4: got %h want %h", pc_plus4_o32, model_seq(exp_pc)); end
      consume(rd, j, bt, st2);
      n_checks++; if (st2 !== 1'b1) begin n_fail++; $display("FAIL rnd_hold_stable: got %b want 1 (txn %0d)", st2, k); end
      exp_pc = model_next(exp_pc, w, j, bt);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_backpressure();
    test_branch();
    test_jump_priority();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
